// File: rtl/gray_area_package.sv
// Shared ECC definitions: Hamming sizing helpers and the scrubber state encoding.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package gray_area_package;

  // Smallest number of Hamming check bits p with 2**p >= data bits + p + 1.
  function automatic int hamming_address_width(input int data_width);
    int p;
    p = 1;
    while ((1 << p) < data_width + p + 1) begin
      p = p + 1;
    end
    return p;
  endfunction

  // Payload + Hamming check bits + overall parity bit (bit 0).
  function automatic int coded_width(input int data_width);
    return data_width + hamming_address_width(data_width) + 1;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READ,
    ST_RDWAIT,
    ST_CHECK,
    ST_WRITE
  } scrub_state_t;

endpackage

// File: rtl/hamming_decode.sv
// SECDED classifier: syndrome over positions 1..N, overall parity in bit 0.
// Latency: purely combinational.
// Backpressure: none; evaluates whatever word is presented.
module hamming_decode
  import gray_area_package::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                                         rst_n,
  input  logic [coded_width(DATA_WIDTH)-1:0]           code_word,
  output logic [1:0]                                   num_errors,
  output logic [hamming_address_width(DATA_WIDTH)-1:0] fault_location
);

  localparam int P  = hamming_address_width(DATA_WIDTH);
  localparam int CW = coded_width(DATA_WIDTH);
  localparam logic [P-1:0] TOP_POS = P'(CW - 1);

  logic         unused_rst_n;
  logic [P-1:0] syndrome;
  logic         overall;

  assign unused_rst_n = rst_n;
  assign overall      = ^code_word;

  // Syndrome is the XOR of the positions of every set bit above the parity bit.
  always_comb begin
    syndrome = '0;
    for (int i = 1; i < CW; i++) begin
      if (code_word[i]) syndrome = syndrome ^ P'(i);
    end
  end

  // Odd overall parity means one flip (syndrome 0 = the parity bit itself);
  // even parity with a nonzero syndrome, or a syndrome past the word, means two.
  always_comb begin
    num_errors = 2'd0;
    if (overall) begin
      num_errors = (syndrome > TOP_POS) ? 2'd2 : 2'd1;
    end else if (syndrome != '0) begin
      num_errors = 2'd2;
    end
  end

  assign fault_location = syndrome;

endmodule

// File: rtl/ecc_scrub_controller.sv
// Background SECDED scrubber: read each word, rewrite single-bit fixes, count/flag double errors.
// Latency: READ(1) + RDWAIT(>=1) + CHECK(1) + WRITE(1 if corrected); SCRUB_INTERVAL idle cycles between words.
// Backpressure: req/addr/wdata held until mem_gnt_i; waits indefinitely for mem_rvalid_i. Option: ECC_SCRUB_ERR_LOG_EN.
module ecc_scrub_controller
  import gray_area_package::*;
#(
  parameter  int DATA_WIDTH     = 32,
  parameter  int DEPTH          = 256,
  parameter  int SCRUB_INTERVAL = 1024,
  parameter  int CNT_WIDTH      = 16,
  localparam int CODED_WIDTH    = coded_width(DATA_WIDTH),
  localparam int ADDR_BITS      = $clog2(DEPTH),
  localparam int LOC_BITS       = hamming_address_width(DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable_i,
  input  logic                   start_i,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [ADDR_BITS-1:0]   mem_addr_o,
  output logic [CODED_WIDTH-1:0] mem_wdata_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [CODED_WIDTH-1:0] mem_rdata_i,
  output logic                   mem_lock_o,
  output logic                   busy_o,
  output logic                   pass_done_o,
  output logic [CNT_WIDTH-1:0]   corr_cnt_o,
  output logic [CNT_WIDTH-1:0]   uncorr_cnt_o,
  output logic                   uncorr_irq_o,
`ifdef ECC_SCRUB_ERR_LOG_EN
  output logic [ADDR_BITS-1:0]   err_addr_o,
  output logic [LOC_BITS-1:0]    err_loc_o,
  output logic [1:0]             err_type_o,
  output logic                   err_valid_o,
`endif
  input  logic                   clr_cnt_i
);

  localparam int TW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam logic [TW-1:0]        TIMER_LOAD = TW'(SCRUB_INTERVAL - 1);
  localparam logic [ADDR_BITS-1:0] ADDR_LAST  = ADDR_BITS'(DEPTH - 1);

  scrub_state_t           state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   manual_q, manual_d;
  logic [CODED_WIDTH-1:0] rdata_q, wdata_q;
  logic [CNT_WIDTH-1:0]   corr_q, uncorr_q;
  logic                   irq_q, pass_done_q;
  logic                   rdata_ld, wdata_ld, corr_inc, uncorr_inc, pass_done_d, word_done;
  logic [1:0]             num_errors;
  logic [LOC_BITS-1:0]    fault_loc;

  hamming_decode #(.DATA_WIDTH(DATA_WIDTH)) u_decode (
    .rst_n         (~rst),
    .code_word     (rdata_q),
    .num_errors    (num_errors),
    .fault_location(fault_loc)
  );

  // State register and scrub-walk bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      addr_q   <= '0;
      manual_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      addr_q   <= addr_d;
      manual_q <= manual_d;
    end
  end

  // Next state; a finished word advances the pointer and picks READ/WAIT/IDLE.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    addr_d      = addr_q;
    manual_d    = manual_q | start_i;
    rdata_ld    = 1'b0;
    wdata_ld    = 1'b0;
    corr_inc    = 1'b0;
    uncorr_inc  = 1'b0;
    pass_done_d = 1'b0;
    word_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_READ;
        end else if (enable_i) begin
          state_d = ST_WAIT;
          timer_d = TIMER_LOAD;
        end
      end
      ST_WAIT: begin
        if (start_i)               state_d = ST_READ;
        else if (!enable_i)        state_d = ST_IDLE;
        else if (timer_q == '0)    state_d = ST_READ;
        else                       timer_d = timer_q - 1'b1;
      end
      ST_READ: begin
        if (mem_gnt_i) state_d = ST_RDWAIT;
      end
      ST_RDWAIT: begin
        if (mem_rvalid_i) begin
          rdata_ld = 1'b1;
          state_d  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        case (num_errors)
          2'd1: begin
            wdata_ld = 1'b1;
            corr_inc = 1'b1;
            state_d  = ST_WRITE;
          end
          2'd2: begin
            uncorr_inc = 1'b1;
            word_done  = 1'b1;
          end
          default: word_done = 1'b1;
        endcase
      end
      ST_WRITE: begin
        if (mem_gnt_i) word_done = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (word_done) begin
      if (addr_q == ADDR_LAST) begin
        addr_d      = '0;
        pass_done_d = 1'b1;
        manual_d    = start_i;
      end else begin
        addr_d = addr_q + 1'b1;
      end
      if (manual_d) begin
        state_d = ST_READ;
      end else if (enable_i) begin
        state_d = ST_WAIT;
        timer_d = TIMER_LOAD;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // Read capture, corrected write data, saturating counters and event pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q     <= '0;
      wdata_q     <= '0;
      corr_q      <= '0;
      uncorr_q    <= '0;
      irq_q       <= 1'b0;
      pass_done_q <= 1'b0;
    end else begin
      if (rdata_ld) rdata_q <= mem_rdata_i;
      if (wdata_ld) wdata_q <= rdata_q ^ (CODED_WIDTH'(1) << fault_loc);
      if (clr_cnt_i)                        corr_q <= '0;
      else if (corr_inc && corr_q != '1)    corr_q <= corr_q + 1'b1;
      if (clr_cnt_i)                        uncorr_q <= '0;
      else if (uncorr_inc && uncorr_q != '1) uncorr_q <= uncorr_q + 1'b1;
      irq_q       <= uncorr_inc;
      pass_done_q <= pass_done_d;
    end
  end

`ifdef ECC_SCRUB_ERR_LOG_EN
  // First error since reset/clear is logged and held until the next clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_addr_o  <= '0;
      err_loc_o   <= '0;
      err_type_o  <= '0;
      err_valid_o <= 1'b0;
    end else if (clr_cnt_i) begin
      err_addr_o  <= '0;
      err_loc_o   <= '0;
      err_type_o  <= '0;
      err_valid_o <= 1'b0;
    end else if (state_q == ST_CHECK && num_errors != 2'd0 && !err_valid_o) begin
      err_addr_o  <= addr_q;
      err_loc_o   <= fault_loc;
      err_type_o  <= num_errors;
      err_valid_o <= 1'b1;
    end
  end
`endif

  assign mem_req_o    = (state_q == ST_READ) || (state_q == ST_WRITE);
  assign mem_we_o     = (state_q == ST_WRITE);
  assign mem_lock_o   = (state_q != ST_IDLE) && (state_q != ST_WAIT);
  assign busy_o       = (state_q != ST_IDLE) && (state_q != ST_WAIT);
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign corr_cnt_o   = corr_q;
  assign uncorr_cnt_o = uncorr_q;
  assign uncorr_irq_o = irq_q;
  assign pass_done_o  = pass_done_q;

endmodule

// File: tb/tb_ecc_scrub_controller.sv
// Bench for ecc_scrub_controller: word-level memory model keyed on a golden copy of each word.
// Latency: memory grants after a programmable stall, returns read data the cycle after grant.
// Backpressure: stall_cfg withholds mem_gnt_i for that many cycles per request.
module tb_ecc_scrub_controller;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int SI    = 3;
  localparam int CNTW  = 4;
  localparam int LOCW  = 6;
  localparam int CW    = 39;
  localparam int AB    = 2;
  localparam int CMAX  = 15;

  logic            clk = 1'b0;
  logic            rst, enable_i, start_i, clr_cnt_i;
  logic            mem_gnt_i, mem_rvalid_i;
  logic [CW-1:0]   mem_rdata_i;
  logic            mem_req_o, mem_we_o, mem_lock_o, busy_o, pass_done_o, uncorr_irq_o;
  logic [AB-1:0]   mem_addr_o;
  logic [CW-1:0]   mem_wdata_o;
  logic [CNTW-1:0] corr_cnt_o, uncorr_cnt_o;
`ifdef ECC_SCRUB_ERR_LOG_EN
  logic [AB-1:0]   err_addr_o;
  logic [LOCW-1:0] err_loc_o;
  logic [1:0]      err_type_o;
  logic            err_valid_o;
`endif

  ecc_scrub_controller #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SCRUB_INTERVAL(SI), .CNT_WIDTH(CNTW)) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .start_i(start_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .mem_lock_o(mem_lock_o), .busy_o(busy_o), .pass_done_o(pass_done_o),
    .corr_cnt_o(corr_cnt_o), .uncorr_cnt_o(uncorr_cnt_o), .uncorr_irq_o(uncorr_irq_o),
`ifdef ECC_SCRUB_ERR_LOG_EN
    .err_addr_o(err_addr_o), .err_loc_o(err_loc_o), .err_type_o(err_type_o), .err_valid_o(err_valid_o),
`endif
    .clr_cnt_i(clr_cnt_i)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [CW-1:0] golden [DEPTH];
  logic [CW-1:0] mem    [DEPTH];

  // Model state
  int  m_corr, m_uncorr, ptr, chk_n, stall_cfg, stall_cnt, rd_addr, cyc;
  bit  m_irq, m_pd, nxt_irq, nxt_pd, in_word, want_wr, chk_act, rd_pend, hold;
  logic          h_we;
  logic [AB-1:0] h_addr;
  logic [CW-1:0] h_wdata;
  int  n_rd, n_wr, n_irq, last_wr_addr;
  int  rd_cyc [$];
  int  rd_addr_q [$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // SECDED encoder: data in non-power-of-two positions, check bits zero the
  // position-XOR syndrome, bit 0 makes total parity even.
  function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
    logic [CW-1:0]   w;
    logic [LOCW-1:0] s;
    int k;
    w = '0;
    k = 0;
    for (int pos = 1; pos < CW; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        w[pos] = d[k];
        k++;
      end
    end
    s = '0;
    for (int pos = 1; pos < CW; pos++) if (w[pos]) s = s ^ LOCW'(pos);
    for (int j = 0; j < LOCW; j++) if (s[j]) w[1 << j] = 1'b1;
    w[0] = ^w[CW-1:1];
    return w;
  endfunction

  task automatic word_done();
    in_word = 0;
    if (ptr == DEPTH - 1) nxt_pd = 1;
    ptr = (ptr + 1) % DEPTH;
  endtask

  // Memory responder + reference model + per-cycle compare, all at the falling edge.
  initial begin
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    cyc = 0; stall_cnt = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        m_corr = 0; m_uncorr = 0; m_irq = 0; m_pd = 0; ptr = 0; in_word = 0; want_wr = 0;
        chk_act = 0; rd_pend = 0; hold = 0; stall_cnt = 0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        check("rst_req", mem_req_o, 0);
        check("rst_lock", mem_lock_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_corr", corr_cnt_o, 0);
        check("rst_uncorr", uncorr_cnt_o, 0);
        check("rst_addr", mem_addr_o, 0);
      end else begin
        check("corr_cnt", corr_cnt_o, m_corr);
        check("uncorr_cnt", uncorr_cnt_o, m_uncorr);
        check("uncorr_irq", uncorr_irq_o, m_irq);
        check("pass_done", pass_done_o, m_pd);
        check("lock", mem_lock_o, mem_req_o || in_word);
        check("busy", busy_o, mem_req_o || in_word);
        if (hold) begin
          check("stall_req", mem_req_o, 1);
          check("stall_addr", mem_addr_o, h_addr);
          check("stall_we", mem_we_o, h_we);
          check("stall_wdata", mem_wdata_o, h_wdata);
        end
        if (uncorr_irq_o) n_irq++;
        // drive memory side for this cycle
        mem_rvalid_i = rd_pend;
        if (rd_pend) mem_rdata_i = mem[rd_addr];
        rd_pend = 0;
        if (mem_req_o) begin
          if (stall_cnt < stall_cfg) begin
            mem_gnt_i = 1'b0;
            stall_cnt++;
          end else begin
            mem_gnt_i = 1'b1;
            stall_cnt = 0;
          end
        end else begin
          mem_gnt_i = 1'b0;
        end
        hold = mem_req_o && !mem_gnt_i;
        h_addr = mem_addr_o; h_we = mem_we_o; h_wdata = mem_wdata_o;
        // predict the effect of the coming rising edge
        nxt_irq = 0; nxt_pd = 0;
        if (clr_cnt_i) begin
          m_corr = 0;
          m_uncorr = 0;
        end
        if (chk_act) begin
          chk_act = 0;
          if (!clr_cnt_i) begin
            if (chk_n == 1 && m_corr != CMAX) m_corr++;
            if (chk_n == 2 && m_uncorr != CMAX) m_uncorr++;
          end
          if (chk_n == 2) nxt_irq = 1;
          if (chk_n == 1) want_wr = 1;
          else word_done();
        end
        if (mem_rvalid_i) begin
          chk_act = 1;
          chk_n = $countones(mem_rdata_i ^ golden[rd_addr]);
        end
        if (mem_req_o && mem_gnt_i) begin
          check("hs_addr", mem_addr_o, ptr);
          check("hs_we", mem_we_o, want_wr);
          if (mem_we_o) begin
            check("wdata", mem_wdata_o, golden[ptr]);
            mem[ptr] = mem_wdata_o;
            want_wr = 0;
            n_wr++;
            last_wr_addr = ptr;
            word_done();
          end else begin
            rd_pend = 1;
            rd_addr = ptr;
            in_word = 1;
            n_rd++;
            rd_cyc.push_back(cyc);
            rd_addr_q.push_back(int'(mem_addr_o));
          end
        end
        m_irq = nxt_irq;
        m_pd = nxt_pd;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1; tick(); start_i = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_cnt_i = 1'b1; tick(); clr_cnt_i = 1'b0;
  endtask

  task automatic wait_pd(input string nm);
    bit seen = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (pass_done_o) begin seen = 1; break; end
    end
    check(nm, seen, 1);
    tick();
  endtask

  task automatic wait_idle(input string nm);
    bit seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy_o) begin seen = 1; break; end
    end
    check(nm, seen, 1);
    tick();
  endtask

  task automatic check_gaps(input string nm, input int gap);
    check({nm, "_count"}, rd_cyc.size(), DEPTH);
    for (int i = 1; i < rd_cyc.size(); i++) check(nm, rd_cyc[i] - rd_cyc[i-1], gap);
  endtask

  initial begin
    int snap;
    bit seen;
    rst = 1'b1; enable_i = 1'b0; start_i = 1'b0; clr_cnt_i = 1'b0; stall_cfg = 0;
    n_rd = 0; n_wr = 0; n_irq = 0; last_wr_addr = -1;
    for (int i = 0; i < DEPTH; i++) begin
      golden[i] = encode(32'hA5C3_0000 + 32'(i * 32'h1357));
      mem[i] = golden[i];
    end
    check("enc_zero", encode(32'h0), 0);
    check("enc_one", encode(32'h1), 39'hF);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Clean pass with interval: READ,RDWAIT,CHECK + 3 WAIT = 6 cycles per word
    rd_cyc.delete(); n_rd = 0; n_wr = 0;
    enable_i = 1'b1;
    wait_pd("pass1_done");
    check_gaps("pass1_gap", 6);
    check("pass1_writes", n_wr, 0);
    check("pass1_corr", corr_cnt_o, 0);

    // Single-bit error at addr 2, coded bit 5
    mem[2][5] = ~mem[2][5];
    n_wr = 0;
    wait_pd("pass2_done");
    check("pass2_writes", n_wr, 1);
    check("pass2_wr_addr", last_wr_addr, 2);
    check("pass2_mem_fixed", mem[2], golden[2]);
    check("pass2_corr", corr_cnt_o, 1);

    // Double-bit error at addr 1, coded bits 3 and 9
    pulse_clr();
    check("clr_corr", corr_cnt_o, 0);
    mem[1][3] = ~mem[1][3];
    mem[1][9] = ~mem[1][9];
    n_wr = 0; n_irq = 0;
    wait_pd("pass3_done");
    check("pass3_writes", n_wr, 0);
    check("pass3_uncorr", uncorr_cnt_o, 1);
    check("pass3_irq_pulses", n_irq, 1);
`ifdef ECC_SCRUB_ERR_LOG_EN
    check("log_valid", err_valid_o, 1);
    check("log_addr", err_addr_o, 1);
    check("log_type", err_type_o, 2);
    check("log_loc", err_loc_o, 10);
`endif
    mem[1] = golden[1];

    // Stalled grants; parity-bit error at addr 0; drop enable during addr 1
    stall_cfg = 5;
    mem[0][0] = ~mem[0][0];
    n_wr = 0;
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (mem_req_o && !mem_we_o && mem_addr_o == 2'd1) begin seen = 1; break; end
    end
    check("reach_addr1", seen, 1);
    tick();
    enable_i = 1'b0;
    check("stall_wr_addr", last_wr_addr, 0);
    check("stall_mem_fixed", mem[0], golden[0]);
    wait_idle("drop_idle");
    snap = n_rd;
    repeat (20) tick();
    check("idle_no_reads", n_rd, snap);
    check("idle_busy", busy_o, 0);
    rd_addr_q.delete();
    stall_cfg = 0;
    enable_i = 1'b1;
    wait_pd("resume_done");
    check("resume_addr", (rd_addr_q.size() > 0) ? rd_addr_q[0] : 99, 2);
    enable_i = 1'b0;
    wait_idle("resume_idle");

    // Manual pass, enable low: back-to-back words, 3 cycles apart
    rd_cyc.delete(); n_rd = 0;
    pulse_start();
    wait_pd("manual_done");
    check_gaps("manual_gap", 3);
    repeat (10) tick();
    check("manual_reads", n_rd, DEPTH);
    check("manual_idle", busy_o, 0);

    // Saturation: 16 corrections into a 4-bit counter
    pulse_clr();
    n_wr = 0;
    for (int p = 0; p < 4; p++) begin
      for (int a = 0; a < DEPTH; a++) mem[a][a + 7] = ~mem[a][a + 7];
      pulse_start();
      wait_pd("sat_pass_done");
      wait_idle("sat_idle");
    end
    check("sat_writes", n_wr, 16);
    check("sat_corr", corr_cnt_o, 4'hF);

    // Reset while waiting for read data
    pulse_start();
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_req_o && mem_gnt_i && !mem_we_o) begin seen = 1; break; end
    end
    check("reach_rdwait", seen, 1);
    tick();
    check("rdwait_lock", mem_lock_o, 1);
    rst = 1'b1;
    #1;
    check("arst_req", mem_req_o, 0);
    check("arst_lock", mem_lock_o, 0);
    check("arst_corr", corr_cnt_o, 0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    check("post_rst_busy", busy_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
